// File: rtl/apb_svt_slave_mem.sv
// APB completer with a word-addressed register bank, a fixed number of wait states
// and an error response. Word 0 is a read-only ID constant.
module apb_svt_slave_mem #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h0000_1000),
    parameter int                    WAIT_CYCLES = 0,
    parameter logic [31:0]           ID_VALUE    = 32'hA5B0_0001
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [2:0]              pprot,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int                    B          = DATA_WIDTH / 8;
    localparam int                    LOG_B      = $clog2(B);
    localparam int                    IDX_W      = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] SPAN       = ADDR_WIDTH'(DEPTH * B);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(B - 1);
    localparam logic [DATA_WIDTH-1:0] ID_WORD    = DATA_WIDTH'(ID_VALUE);
    localparam logic [3:0]            WAIT_INIT  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                  state_reg;
    logic [3:0]              cnt_reg;
    logic                    we_reg;
    logic                    err_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic [B-1:0]            strb_reg;
    logic [2:0]              prot_reg;
    logic                    pready_reg;
    logic                    pslverr_reg;
    logic [DATA_WIDTH-1:0]   prdata_reg;

    logic [DATA_WIDTH-1:0]   bank_reg [DEPTH];

    // Live decode of the setup-phase address.
    logic [ADDR_WIDTH-1:0]   offset_in;
    logic                    in_range_in;
    logic                    aligned_in;
    logic [IDX_W-1:0]        idx_in;
    logic                    err_in;

    assign offset_in   = paddr - BASE_ADDR;
    assign in_range_in = (paddr >= BASE_ADDR) && (offset_in < SPAN);
    assign aligned_in  = (paddr & ALIGN_MASK) == '0;
    assign idx_in      = IDX_W'(offset_in >> LOG_B);
    assign err_in      = !in_range_in || !aligned_in || (pwrite && (idx_in == '0));

    // With no wait states the response is formed straight from the setup phase,
    // otherwise from the latched transfer.
    logic                    resp_err;
    logic                    resp_we;
    logic [IDX_W-1:0]        resp_idx;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   resp_data;

    always_comb begin
        resp_err = err_reg;
        resp_we  = we_reg;
        resp_idx = idx_reg;
        if (state_reg == ST_IDLE) begin
            resp_err = err_in;
            resp_we  = pwrite;
            resp_idx = idx_in;
        end
        rd_word   = (resp_idx == '0) ? ID_WORD : bank_reg[resp_idx];
        resp_data = (resp_we || resp_err) ? '0 : rd_word;
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            we_reg      <= 1'b0;
            err_reg     <= 1'b0;
            idx_reg     <= '0;
            wdata_reg   <= '0;
            strb_reg    <= '0;
            prot_reg    <= '0;
            pready_reg  <= 1'b0;
            pslverr_reg <= 1'b0;
            prdata_reg  <= '0;
        end else begin
            pready_reg  <= 1'b0;
            pslverr_reg <= 1'b0;
            prdata_reg  <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (psel && !penable) begin
                        we_reg    <= pwrite;
                        err_reg   <= err_in;
                        idx_reg   <= idx_in;
                        wdata_reg <= pwdata;
                        strb_reg  <= pstrb;
                        prot_reg  <= pprot;
                        cnt_reg   <= WAIT_INIT;
                        if (WAIT_CYCLES > 0) begin
                            state_reg <= ST_WAIT;
                        end else begin
                            state_reg   <= ST_DONE;
                            pready_reg  <= 1'b1;
                            pslverr_reg <= resp_err;
                            prdata_reg  <= resp_data;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!psel) begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                        if (cnt_reg <= 4'd1) begin
                            state_reg   <= ST_DONE;
                            pready_reg  <= 1'b1;
                            pslverr_reg <= resp_err;
                            prdata_reg  <= resp_data;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    // A write lands on the DONE edge only if the master is still selecting us.
    logic                  commit_write;
    logic [DEPTH-1:0]      word_we;
    logic [DATA_WIDTH-1:0] byte_mask;

    assign commit_write = (state_reg == ST_DONE) && psel && we_reg && !err_reg;
    assign word_we[0]   = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_word_we
            assign word_we[gi] = commit_write && (idx_reg == IDX_W'(gi));
        end
        for (gi = 0; gi < B; gi++) begin : g_byte_mask
            assign byte_mask[gi*8 +: 8] = {8{strb_reg[gi]}};
        end
    endgenerate

    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int w = 0; w < DEPTH; w++) begin
                bank_reg[w] <= '0;
            end
        end else begin
            for (int w = 0; w < DEPTH; w++) begin
                if (word_we[w]) begin
                    bank_reg[w] <= (bank_reg[w] & ~byte_mask) | (wdata_reg & byte_mask);
                end
            end
        end
    end

    // Protection attributes are kept for observation only.
    logic unused_prot;
    assign unused_prot = ^prot_reg;

    assign prdata  = prdata_reg;
    assign pready  = pready_reg;
    assign pslverr = pslverr_reg;

endmodule

// File: tb/tb_apb_svt_slave_mem.sv
// Bench for apb_svt_slave_mem: directed scenarios plus randomized transfers
// checked against a behavioural bank model.
module tb_apb_svt_slave_mem;

    localparam int          DEPTH = 16;
    localparam int          WAITC = 2;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [31:0] IDV   = 32'hA5B0_0001;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [2:0]  pprot = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] model_mem [DEPTH];

    apb_svt_slave_mem #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (DEPTH),
        .BASE_ADDR  (BASE),
        .WAIT_CYCLES(WAITC),
        .ID_VALUE   (IDV)
    ) dut (
        .pclk   (pclk),
        .preset (preset),
        .psel   (psel),
        .penable(penable),
        .pwrite (pwrite),
        .paddr  (paddr),
        .pwdata (pwdata),
        .pstrb  (pstrb),
        .pprot  (pprot),
        .prdata (prdata),
        .pready (pready),
        .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    // Reference: what a transfer should return, and its effect on the bank.
    task automatic model_xfer(input bit we, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, output logic [31:0] exp_rd, output bit exp_err);
        int unsigned idx;
        bit in_range;
        bit aligned;
        in_range = (addr >= BASE) && (addr < BASE + DEPTH * 4);
        aligned  = (addr % 4) == 0;
        idx      = (addr - BASE) / 4;
        exp_err  = !in_range || !aligned || (we && idx == 0);
        exp_rd   = '0;
        if (!exp_err) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
                end
            end else begin
                exp_rd = (idx == 0) ? IDV : model_mem[idx];
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    // Drives one complete transfer; inputs are scrambled during the access phase.
    // acc_cycles = number of access cycles up to and including pready (0 = timeout).
    // stray = outputs nonzero while pready low, or pready held longer than one cycle.
    task automatic do_xfer(input bit we, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [31:0] rd, output bit err,
                           output int acc_cycles, output bit stray);
        stray = 1'b0;
        rd = '0;
        err = 1'b0;
        acc_cycles = 0;
        psel = 1'b1; penable = 1'b0; pwrite = we; paddr = addr; pwdata = data; pstrb = strb;
        pprot = 3'($urandom);
        @(posedge pclk); #1;
        penable = 1'b1;
        pwrite = 1'($urandom); paddr = $urandom; pwdata = $urandom; pstrb = 4'($urandom);
        for (int c = 1; c <= 20; c++) begin
            if (pready === 1'b1) begin
                acc_cycles = c;
                rd = prdata;
                err = pslverr;
                break;
            end
            if (prdata !== '0 || pslverr !== 1'b0) stray = 1'b1;
            @(posedge pclk); #1;
        end
        if (acc_cycles != 0) begin
            @(posedge pclk); #1;
            if (pready !== 1'b0 || prdata !== '0 || pslverr !== 1'b0) stray = 1'b1;
        end
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        preset = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        model_clear();
        vectors++;
        if (pready !== 1'b0) begin
            miscompares++; $display("FAIL reset_pready: got %b want 0", pready);
        end
        vectors++;
        if (pslverr !== 1'b0) begin
            miscompares++; $display("FAIL reset_pslverr: got %b want 0", pslverr);
        end
        vectors++;
        if (prdata !== 32'h0) begin
            miscompares++; $display("FAIL reset_prdata: got %h want 0", prdata);
        end
        preset = 1'b0;
        @(posedge pclk); #1;
    endtask

    task automatic test_write_read();
        logic [31:0] rd, exp_rd;
        bit err, exp_err, stray;
        int cyc;
        model_xfer(1'b1, 32'h1008, 32'hDEAD_BEEF, 4'hF, exp_rd, exp_err);
        do_xfer(1'b1, 32'h1008, 32'hDEAD_BEEF, 4'hF, rd, err, cyc, stray);
        vectors++;
        if (err !== exp_err || cyc != WAITC + 1 || stray) begin
            miscompares++; $display("FAIL wr_1008: err=%b cyc=%0d stray=%b want err=%b cyc=%0d stray=0", err, cyc, stray, exp_err, WAITC + 1);
        end
        model_xfer(1'b0, 32'h1008, 32'h0, 4'h0, exp_rd, exp_err);
        do_xfer(1'b0, 32'h1008, 32'h0, 4'h0, rd, err, cyc, stray);
        vectors++;
        if (rd !== 32'hDEAD_BEEF || rd !== exp_rd) begin
            miscompares++; $display("FAIL rd_1008_data: got %h want %h", rd, 32'hDEAD_BEEF);
        end
        vectors++;
        if (err !== 1'b0 || cyc != WAITC + 1 || stray) begin
            miscompares++; $display("FAIL rd_1008_resp: err=%b cyc=%0d stray=%b want err=0 cyc=%0d stray=0", err, cyc, stray, WAITC + 1);
        end
    endtask

    task automatic test_strobes();
        logic [31:0] rd, exp_rd;
        bit err, exp_err, stray;
        int cyc;
        model_xfer(1'b1, 32'h1004, 32'h1122_3344, 4'hF, exp_rd, exp_err);
        do_xfer(1'b1, 32'h1004, 32'h1122_3344, 4'hF, rd, err, cyc, stray);
        model_xfer(1'b1, 32'h1004, 32'hAABB_CCDD, 4'b0101, exp_rd, exp_err);
        do_xfer(1'b1, 32'h1004, 32'hAABB_CCDD, 4'b0101, rd, err, cyc, stray);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++; $display("FAIL strb_wr_err: got %b want 0", err);
        end
        model_xfer(1'b0, 32'h1004, 32'h0, 4'h0, exp_rd, exp_err);
        do_xfer(1'b0, 32'h1004, 32'h0, 4'h0, rd, err, cyc, stray);
        vectors++;
        if (rd !== 32'h11BB_33DD || rd !== exp_rd) begin
            miscompares++; $display("FAIL strb_rd_1004: got %h want %h", rd, 32'h11BB_33DD);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, exp_rd;
        bit err, exp_err, stray;
        int cyc;
        model_xfer(1'b0, 32'h1040, 32'h0, 4'h0, exp_rd, exp_err);
        do_xfer(1'b0, 32'h1040, 32'h0, 4'h0, rd, err, cyc, stray);
        vectors++;
        if (err !== 1'b1 || rd !== 32'h0 || cyc != WAITC + 1 || stray) begin
            miscompares++; $display("FAIL err_oor: err=%b rd=%h cyc=%0d stray=%b want err=1 rd=0 cyc=%0d stray=0", err, rd, cyc, stray, WAITC + 1);
        end
        model_xfer(1'b1, 32'h1002, 32'hFFFF_FFFF, 4'hF, exp_rd, exp_err);
        do_xfer(1'b1, 32'h1002, 32'hFFFF_FFFF, 4'hF, rd, err, cyc, stray);
        vectors++;
        if (err !== 1'b1 || cyc != WAITC + 1 || stray) begin
            miscompares++; $display("FAIL err_misaligned: err=%b cyc=%0d stray=%b want err=1 cyc=%0d stray=0", err, cyc, stray, WAITC + 1);
        end
        model_xfer(1'b0, 32'h1004, 32'h0, 4'h0, exp_rd, exp_err);
        do_xfer(1'b0, 32'h1004, 32'h0, 4'h0, rd, err, cyc, stray);
        vectors++;
        if (rd !== exp_rd || err !== 1'b0) begin
            miscompares++; $display("FAIL err_misaligned_nochange: got %h err=%b want %h err=0", rd, err, exp_rd);
        end
        model_xfer(1'b1, 32'h1000, 32'h1234_5678, 4'hF, exp_rd, exp_err);
        do_xfer(1'b1, 32'h1000, 32'h1234_5678, 4'hF, rd, err, cyc, stray);
        vectors++;
        if (err !== 1'b1 || stray) begin
            miscompares++; $display("FAIL err_wr_id: err=%b stray=%b want err=1 stray=0", err, stray);
        end
        model_xfer(1'b0, 32'h1000, 32'h0, 4'h0, exp_rd, exp_err);
        do_xfer(1'b0, 32'h1000, 32'h0, 4'h0, rd, err, cyc, stray);
        vectors++;
        if (rd !== IDV || rd !== exp_rd || err !== 1'b0) begin
            miscompares++; $display("FAIL rd_id: got %h err=%b want %h err=0", rd, err, IDV);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd1, rd2, rd3, exp1, exp2, exp3, wval;
        bit e1, e2, e3, x1, x2, x3, s1, s2, s3;
        int c1, c2, c3;
        wval = $urandom;
        model_xfer(1'b0, 32'h100C, 32'h0, 4'h0, exp1, x1);
        model_xfer(1'b1, 32'h100C, wval, 4'hF, exp2, x2);
        model_xfer(1'b0, 32'h100C, 32'h0, 4'h0, exp3, x3);
        do_xfer(1'b0, 32'h100C, 32'h0, 4'h0, rd1, e1, c1, s1);
        do_xfer(1'b1, 32'h100C, wval, 4'hF, rd2, e2, c2, s2);
        do_xfer(1'b0, 32'h100C, 32'h0, 4'h0, rd3, e3, c3, s3);
        vectors++;
        if (c1 != WAITC + 1 || c2 != WAITC + 1 || c3 != WAITC + 1) begin
            miscompares++; $display("FAIL b2b_cycles: got %0d/%0d/%0d want %0d each", c1, c2, c3, WAITC + 1);
        end
        vectors++;
        if (rd1 !== exp1 || e1 !== x1 || s1) begin
            miscompares++; $display("FAIL b2b_rd1: got %h err=%b stray=%b want %h err=%b", rd1, e1, s1, exp1, x1);
        end
        vectors++;
        if (rd3 !== wval || rd3 !== exp3 || e2 !== x2 || e3 !== x3 || s2 || s3) begin
            miscompares++; $display("FAIL b2b_rd2: got %h err=%b/%b want %h", rd3, e2, e3, wval);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd, exp_rd;
        bit err, exp_err, stray, seen_ready;
        int cyc;
        seen_ready = 1'b0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h1010; pwdata = 32'h5555_5555; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        if (pready === 1'b1) seen_ready = 1'b1;
        @(posedge pclk); #1;
        if (pready === 1'b1) seen_ready = 1'b1;
        psel = 1'b0; penable = 1'b0;
        repeat (5) begin
            @(posedge pclk); #1;
            if (pready === 1'b1 || pslverr !== 1'b0) seen_ready = 1'b1;
        end
        vectors++;
        if (seen_ready) begin
            miscompares++; $display("FAIL abort_pready: got pready/pslverr asserted want never");
        end
        model_xfer(1'b0, 32'h1010, 32'h0, 4'h0, exp_rd, exp_err);
        do_xfer(1'b0, 32'h1010, 32'h0, 4'h0, rd, err, cyc, stray);
        vectors++;
        if (rd !== 32'h0 || rd !== exp_rd || err !== 1'b0) begin
            miscompares++; $display("FAIL abort_rd_1010: got %h err=%b want 0 err=0", rd, err);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, exp_rd, wval;
        bit err, exp_err, stray;
        int cyc;
        model_xfer(1'b1, 32'h1014, 32'h1, 4'hF, exp_rd, exp_err);
        do_xfer(1'b1, 32'h1014, 32'h1, 4'hF, rd, err, cyc, stray);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h1014;
        @(posedge pclk); #1;
        penable = 1'b1;
        preset = 1'b1;
        @(posedge pclk); #1;
        model_clear();
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        vectors++;
        if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'h0) begin
            miscompares++; $display("FAIL midreset_outputs: got rdy=%b err=%b rd=%h want 0/0/0", pready, pslverr, prdata);
        end
        @(posedge pclk); #1;
        model_xfer(1'b0, 32'h1014, 32'h0, 4'h0, exp_rd, exp_err);
        do_xfer(1'b0, 32'h1014, 32'h0, 4'h0, rd, err, cyc, stray);
        vectors++;
        if (rd !== 32'h0 || rd !== exp_rd || cyc != WAITC + 1) begin
            miscompares++; $display("FAIL midreset_rd_1014: got %h cyc=%0d want 0 cyc=%0d", rd, cyc, WAITC + 1);
        end
        wval = $urandom;
        model_xfer(1'b1, 32'h1018, wval, 4'hF, exp_rd, exp_err);
        do_xfer(1'b1, 32'h1018, wval, 4'hF, rd, err, cyc, stray);
        model_xfer(1'b0, 32'h1018, 32'h0, 4'h0, exp_rd, exp_err);
        do_xfer(1'b0, 32'h1018, 32'h0, 4'h0, rd, err, cyc, stray);
        vectors++;
        if (rd !== exp_rd || err !== 1'b0 || cyc != WAITC + 1 || stray) begin
            miscompares++; $display("FAIL midreset_recover: got %h err=%b cyc=%0d want %h err=0", rd, err, cyc, exp_rd);
        end
    endtask

    task automatic test_penable_only();
        bit seen_ready;
        seen_ready = 1'b0;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h1008;
        repeat (4) begin
            @(posedge pclk); #1;
            if (pready === 1'b1) seen_ready = 1'b1;
        end
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        vectors++;
        if (seen_ready) begin
            miscompares++; $display("FAIL penable_only: got pready=1 want 0");
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, exp_rd, addr, data;
        logic [3:0] strb;
        bit we, err, exp_err, stray;
        int cyc;
        for (int n = 0; n < 60; n++) begin
            we   = 1'($urandom);
            data = $urandom;
            strb = 4'($urandom);
            if ($urandom_range(0, 4) != 0) addr = BASE + 4 * $urandom_range(0, DEPTH - 1);
            else addr = 32'h0FF0 + $urandom_range(0, 32'h5F);
            model_xfer(we, addr, data, strb, exp_rd, exp_err);
            do_xfer(we, addr, data, strb, rd, err, cyc, stray);
            vectors++;
            if (rd !== exp_rd || err !== exp_err || cyc != WAITC + 1 || stray) begin
                miscompares++;
                $display("FAIL rand_%0d: we=%b addr=%h got rd=%h err=%b cyc=%0d stray=%b want rd=%h err=%b cyc=%0d",
                         n, we, addr, rd, err, cyc, stray, exp_rd, exp_err, WAITC + 1);
            end
            repeat ($urandom_range(0, 2)) @(posedge pclk);
            #0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_strobes();
        test_errors();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_penable_only();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
